// File: rtl/mux_sel_rr_arbiter_if.sv
// Request/grant bundle between four requesters, the arbiter and the 4:1 mux.
// Latency: none, wires only.
// Backpressure: none; a requester holds its req bit until it is finished with the output.
// Ports: req_in[3:0] per-channel request; sel_out[1:0] mux select; gnt_out[3:0] one-hot grant;
//        valid_out is high while any grant is active.
interface mux_sel_rr_arbiter_if;
    logic [3:0] req_in;
    logic [1:0] sel_out;
    logic [3:0] gnt_out;
    logic       valid_out;

    // Arbiter side.
    modport master (
        input  req_in,
        output sel_out,
        output gnt_out,
        output valid_out
    );

    // Requester / mux side.
    modport slave (
        output req_in,
        input  sel_out,
        input  gnt_out,
        input  valid_out
    );
endinterface

// File: rtl/mux_sel_rr_arbiter.sv
// Four-channel round-robin arbiter that drives the select code of a 4:1 bit mux.
// Latency: 1 cycle request-to-grant from idle; 0-cycle bubble on handover.
// Backpressure: a grant is capped at MAX_HOLD cycles, then priority rotates so no channel starves.
// Ports: clk_in rising-edge clock; rst_n_in synchronous active-low reset;
//        arb (master modport) carries req_in in, and sel_out / gnt_out / valid_out out.
// MAX_HOLD must lie in 1..255 and 2**CNT_W must exceed MAX_HOLD.
module mux_sel_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    mux_sel_rr_arbiter_if.master   arb
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q;
    logic [1:0]       sel_q;
    logic [3:0]       gnt_q;
    logic             valid_q;
    logic [1:0]       ptr_q;
    logic [CNT_W-1:0] hold_cnt_q;

    // Returns {found, index}: first set bit of req scanning start, start+1, ... mod 4.
    // Iterating the offsets downward lets the smallest offset overwrite the others.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (req[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

    logic [1:0] search_start;
    logic [2:0] pick;
    logic       pick_found;
    logic [1:0] pick_idx;
    logic       hold_expired;
    logic       release_grant;

    always_comb begin
        // Idle searches from the rotating pointer; a releasing grant searches from
        // the channel after the current owner, which is the value ptr is about to take.
        search_start  = (state_q == GRANT) ? (sel_q + 2'd1) : ptr_q;
        pick          = rr_pick(arb.req_in, search_start);
        pick_found    = pick[2];
        pick_idx      = pick[1:0];
        hold_expired  = (hold_cnt_q == CNT_W'(MAX_HOLD));
        release_grant = !arb.req_in[sel_q] || hold_expired;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            sel_q      <= 2'd0;
            gnt_q      <= 4'b0000;
            valid_q    <= 1'b0;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // sel_q is left alone so the mux input stays stable while idle.
                    if (pick_found) begin
                        sel_q      <= pick_idx;
                        gnt_q      <= 4'b0001 << pick_idx;
                        valid_q    <= 1'b1;
                        hold_cnt_q <= CNT_W'(1);
                        state_q    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!release_grant) begin
                        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                    end else begin
                        ptr_q <= sel_q + 2'd1;
                        if (pick_found) begin
                            // Back-to-back handover; the owner can only win again
                            // when it is the sole remaining requester.
                            sel_q      <= pick_idx;
                            gnt_q      <= 4'b0001 << pick_idx;
                            valid_q    <= 1'b1;
                            hold_cnt_q <= CNT_W'(1);
                        end else begin
                            gnt_q   <= 4'b0000;
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 4'b0000;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign arb.sel_out   = sel_q;
    assign arb.gnt_out   = gnt_q;
    assign arb.valid_out = valid_q;

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Bench for mux_sel_rr_arbiter: three instances (MAX_HOLD 8, 4, 1) share one stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_mux_sel_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;

    int n_checks;
    int n_fail;

    mux_sel_rr_arbiter_if if8 ();
    mux_sel_rr_arbiter_if if4 ();
    mux_sel_rr_arbiter_if if1 ();

    assign if8.req_in = req;
    assign if4.req_in = req;
    assign if1.req_in = req;

    mux_sel_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut8 (.clk_in(clk), .rst_n_in(rst_n), .arb(if8.master));
    mux_sel_rr_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut4 (.clk_in(clk), .rst_n_in(rst_n), .arb(if4.master));
    mux_sel_rr_arbiter #(.MAX_HOLD(1), .CNT_W(2)) dut1 (.clk_in(clk), .rst_n_in(rst_n), .arb(if1.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs gathered into arrays so the model compare can loop over instances.
    logic [1:0] o_sel [3];
    logic [3:0] o_gnt [3];
    logic       o_vld [3];
    assign o_sel[0] = if8.sel_out;  assign o_gnt[0] = if8.gnt_out;  assign o_vld[0] = if8.valid_out;
    assign o_sel[1] = if4.sel_out;  assign o_gnt[1] = if4.gnt_out;  assign o_vld[1] = if4.valid_out;
    assign o_sel[2] = if1.sel_out;  assign o_gnt[2] = if1.gnt_out;  assign o_vld[2] = if1.valid_out;

    // ---------------- behavioural model ----------------
    // Per instance: who owns the output (or nobody), the last owner, the rotating
    // pointer and how many cycles the owner has had so far.
    int hold_lim [3] = '{8, 4, 1};
    int m_busy   [3];
    int m_sel    [3];
    int m_ptr    [3];
    int m_held   [3];
    bit m_live;

    initial begin
        m_live = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_busy[k] = 0; m_sel[k] = 0; m_ptr[k] = 0; m_held[k] = 0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int nb, ns, np, nh, start, win;
            nb = m_busy[k]; ns = m_sel[k]; np = m_ptr[k]; nh = m_held[k];
            if (!rst_n) begin
                nb = 0; ns = 0; np = 0; nh = 0;
            end else if (m_busy[k] != 0 && req[m_sel[k]] && m_held[k] < hold_lim[k]) begin
                nh = m_held[k] + 1;
            end else begin
                if (m_busy[k] != 0) begin
                    start = (m_sel[k] + 1) % 4;
                    np    = start;
                end else begin
                    start = m_ptr[k];
                end
                win = -1;
                for (int off = 0; off < 4; off++) begin
                    if (win < 0 && req[(start + off) % 4]) win = (start + off) % 4;
                end
                if (win >= 0) begin
                    nb = 1; ns = win; nh = 1;
                end else begin
                    nb = 0;
                end
            end
            m_busy[k] <= nb; m_sel[k] <= ns; m_ptr[k] <= np; m_held[k] <= nh;
        end
        m_live <= 1'b1;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Model compare on every cycle, for every instance.
    always @(negedge clk) begin
        if (m_live) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("model_gnt[%0d]", k), int'(o_gnt[k]), (m_busy[k] != 0) ? (1 << m_sel[k]) : 0);
                check($sformatf("model_vld[%0d]", k), int'(o_vld[k]), m_busy[k]);
                check($sformatf("model_sel[%0d]", k), int'(o_sel[k]), m_sel[k]);
                check($sformatf("vld_is_or_gnt[%0d]", k), int'(o_vld[k]), int'(|o_gnt[k]));
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    // Inputs change on the falling edge; the DUTs sample them on the next rising edge.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        req      = 4'b1111;

        // Reset held for 3 edges with every channel requesting.
        repeat (3) begin
            @(negedge clk);
            check("rst_sel", int'(if8.sel_out), 0);
            check("rst_gnt", int'(if8.gnt_out), 0);
            check("rst_vld", int'(if8.valid_out), 0);
        end
        rst_n = 1'b1;

        // First grant goes to channel 0, then strict rotation with back-to-back handover.
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            check("rot8_gnt", int'(if8.gnt_out), 1 << ((j / 8) % 4));
            check("rot8_vld", int'(if8.valid_out), 1);
            check("rot4_gnt", int'(if4.gnt_out), 1 << ((j / 4) % 4));
            check("rot1_gnt", int'(if1.gnt_out), 1 << (j % 4));
        end

        // Drop everything: back to idle with sel held at the last owner.
        req = 4'b0000;
        @(negedge clk);
        check("idle_vld", int'(if8.valid_out), 0);
        check("idle_sel8", int'(if8.sel_out), 0);
        check("idle_sel4", int'(if4.sel_out), 1);
        check("idle_sel1", int'(if1.sel_out), 3);

        // Single request on channel 2 for 3 cycles.
        req = 4'b0100;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("single_gnt", int'(if8.gnt_out), 4'b0100);
            check("single_sel", int'(if8.sel_out), 2);
        end
        req = 4'b0000;
        @(negedge clk);
        check("single_end_vld", int'(if8.valid_out), 0);
        check("single_end_sel", int'(if8.sel_out), 2);

        // Pointer is now 3: channel 3 wins, expires, and the wrap hands over to 0.
        req = 4'b1001;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            check("wrap_gnt", int'(if8.gnt_out), (j < 8) ? 4'b1000 : 4'b0001);
        end
        check("wrap_sel", int'(if8.sel_out), 0);

        // Sole requester keeps the output across hold expiry without a gap.
        req = 4'b0010;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("sole_gnt8", int'(if8.gnt_out), 4'b0010);
            check("sole_gnt4", int'(if4.gnt_out), 4'b0010);
            check("sole_gnt1", int'(if1.gnt_out), 4'b0010);
        end

        // Channel 2 granted for 5 cycles, then a one-cycle reset mid-grant.
        req = 4'b0100;
        repeat (5) @(negedge clk);
        check("pre_rst_gnt", int'(if8.gnt_out), 4'b0100);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_sel", int'(if8.sel_out), 0);
        check("midrst_gnt", int'(if8.gnt_out), 0);
        check("midrst_vld", int'(if8.valid_out), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("regrant_gnt", int'(if8.gnt_out), 4'b0100);
        check("regrant_sel", int'(if8.sel_out), 2);

        // Channel 0 joins: the MAX_HOLD=4 instance must give channel 2 exactly
        // 4 cycles counted from the re-grant, proving the counter restarted at 1.
        req = 4'b0101;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("hold4_gnt", int'(if4.gnt_out), (j < 3) ? 4'b0100 : 4'b0001);
        end

        req = 4'b0000;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_sel_rr_arbiter.md
# mux_sel_rr_arbiter

Four-channel round-robin arbiter that sits directly upstream of the 4:1 bit multiplexer. It drives the mux select bus and tells each requester when its data bit is on the mux output. Requesters raise `req_in[i]` to own the shared output. The arbiter grants one channel at a time, caps each grant at `MAX_HOLD` cycles, and rotates priority so no channel starves.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one channel may stay granted; legal range 1..255.
- `CNT_W`, default 8: width of the internal hold counter; must satisfy 2^CNT_W > MAX_HOLD.
- `clk_in`  input  1  single clock; all state updates on the rising edge.
- `rst_n_in`  input  1  reset, synchronous, active-low.
- `req_in`  input  4  per-channel request; bit i = channel i wants the mux output.
- `sel_out`  output  2  select code for the mux `sel_in`; index of the current or last granted channel.
- `gnt_out`  output  4  one-hot grant; bit i high = channel i owns the mux output this cycle.
- `valid_out`  output  1  high when a grant is active; this equals the OR of `gnt_out`.

## Operation
- Reset applies when `rst_n_in`=0 at a rising edge. Results: state IDLE, `sel_out`=2'd0, `gnt_out`=4'b0000, `valid_out`=0, priority pointer `ptr`=2'd0, `hold_cnt`=0. Reset overrides every other event, including a grant in progress.
- The search function scans `req_in` at indices `start`, `start`+1, `start`+2, `start`+3, all mod 4. The first index found set is the winner.
- **IDLE**:
  - `gnt_out`=0 and `valid_out`=0.
  - `sel_out` holds its last value, so the mux input stays stable.
  - If `req_in`≠0, search from `ptr`. At the next edge, register the winner into `sel_out` and `gnt_out`, set `valid_out`=1 and `hold_cnt`=1, and go to GRANT.
  - If `req_in`=0, stay in IDLE.
- **GRANT**:
  - The release condition is `req_in[sel_out]`=0 OR `hold_cnt`=`MAX_HOLD`.
  - If there is no release: `hold_cnt` increments and the grant is unchanged. Requests from other channels are ignored.
  - On release, `ptr` becomes `sel_out`+1 mod 4. In the same cycle, search from `sel_out`+1 using the current `req_in`.
    - If a winner is found, grant it at the next edge with `hold_cnt`=1 and stay in GRANT. There is no bubble cycle.
    - The current channel can win again only if it is the sole requester and is still requesting (for example, on `MAX_HOLD` expiry).
    - If no request is pending, go to IDLE with `gnt_out`=0 and `valid_out`=0. `sel_out` is unchanged.
- `gnt_out` is always one-hot or zero. When `valid_out`=1, `gnt_out`[`sel_out`]=1.
- `sel_out` only changes on an edge where a new grant is issued.
- `ptr` wraps from 3 to 0.

## Timing
- All outputs are registered. No combinational path exists from `req_in` to any output.
- Request-to-grant latency from IDLE: 1 cycle. `req_in` sampled at edge k produces the grant after edge k.
- Handover latency: 0 bubble cycles. The new grant appears on the edge that drops the old one.
- A continuous request with other channels waiting holds the grant for exactly `MAX_HOLD` cycles.
- With `MAX_HOLD`=1, the grant rotates every cycle among the active requesters.
- Dropping a request ends the grant at the next edge. The channel keeps the grant for the cycle in which `req_in` falls.
- Worst-case wait for a continuously requesting channel: 3×`MAX_HOLD` cycles plus 1.
- Reset asserted mid-grant: outputs reach their reset values after that edge.
- After reset release, the first grant follows the IDLE rule with `ptr`=0.

## Test plan
- **Reset values.** Hold `rst_n_in`=0 for 3 cycles while `req_in`=4'b1111. Required: `sel_out`=0, `gnt_out`=0, `valid_out`=0 throughout. Release reset. One edge later, `gnt_out`=4'b0001 and `sel_out`=0.
- **Single request.** `req_in`=4'b0100 for 3 cycles, then 0. Required: `gnt_out`=4'b0100 and `sel_out`=2 from the next edge, for 3 cycles. Then `valid_out`=0 and `sel_out` stays 2.
- **Hold cap and rotation.** `MAX_HOLD`=8, `req_in`=4'b1111 held. Required: grants to channels 0,1,2,3,0 in turn, each lasting exactly 8 cycles, with no gap between grants.
- **Wrap-around.** Channel 3 granted, then `req_in`=4'b1001 after its release. Required: next grant goes to channel 0 (not 3), and `ptr` becomes 0.
- **Sole requester on expiry.** `MAX_HOLD`=4, `req_in`=4'b0010 held for 10 cycles. Required: `gnt_out`=4'b0010 continuously for 10 cycles, with `hold_cnt` restarting at 1 every 4 cycles and no deassertion.
- **Reset mid-grant.** Pull `rst_n_in` low for 1 cycle during a grant to channel 2 with `hold_cnt`=5. Required: all outputs at reset values after that edge. After release with `req_in`=4'b0100, channel 2 is re-granted with `hold_cnt`=1.
